// File: rtl/bitonic_stream_out.sv
// bitonic_stream_out: parallel-to-serial output stage of the bitonic sorter.
// Takes one sorted vector through a valid/ready handshake and emits its
// elements one per cycle. A single pending buffer lets the next vector be
// accepted while the current one streams, so back-to-back vectors leave no
// bubbles on the output.
module bitonic_stream_out #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM        = 8,
  parameter bit REVERSE    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH*NUM-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(NUM)-1:0]    out_index,
  output logic                      out_last
);

  localparam int IDX_W = $clog2(NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  // Buffer occupancy: bit 1 is act_valid, bit 0 is pend_valid. 2'b01 is
  // unreachable and falls into the default recovery arm.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_STREAM = 2'b10,
    ST_FULL   = 2'b11
  } state_e;

  // Element i of a packed vector lines up with in_data bits
  // [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH].
  typedef logic [NUM-1:0][DATA_WIDTH-1:0] vec_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  vec_t             act_q, pend_q;

  logic act_valid, pend_valid;
  logic in_hs, out_hs, last_hs;
  logic load_act_in, load_act_pend, load_pend;

  assign act_valid  = (state_q == ST_STREAM) || (state_q == ST_FULL);
  assign pend_valid = (state_q == ST_FULL);

  // in_ready depends on registered state only, so upstream sees no
  // combinational path from out_ready or in_valid.
  assign in_ready = !pend_valid;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = act_valid && out_ready;
  assign last_hs  = out_hs && (cnt_q == LAST_IDX);

  // Next-state and buffer-load selection for the occupancy FSM.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch; blocking '=' belongs here, '<=' in flops.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load_act_in   = 1'b0;
    load_act_pend = 1'b0;
    load_pend     = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_hs) begin
          state_d     = ST_STREAM;
          cnt_d       = '0;
          load_act_in = 1'b1;
        end
      end
      ST_STREAM: begin
        if (last_hs) begin
          cnt_d = '0;
          if (in_hs) begin
            // New vector replaces the finishing one on the same edge.
            load_act_in = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          if (out_hs) cnt_d = cnt_q + IDX_W'(1);
          if (in_hs) begin
            state_d   = ST_FULL;
            load_pend = 1'b1;
          end
        end
      end
      ST_FULL: begin
        // in_ready is low here, so no input handshake can occur.
        if (last_hs) begin
          state_d       = ST_STREAM;
          cnt_d         = '0;
          load_act_pend = 1'b1;
        end else if (out_hs) begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  // Occupancy state and element counter; reset discards both buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Vector storage for the active and pending buffers.
  // NOTE: data registers carry no reset; the valid flags qualify them and
  // out_data is forced to zero whenever the active buffer is empty.
  always_ff @(posedge clk) begin
    if (load_act_in) begin
      act_q <= vec_t'(in_data);
    end else if (load_act_pend) begin
      act_q <= pend_q;
    end
    if (load_pend) begin
      pend_q <= vec_t'(in_data);
    end
  end

  assign out_valid = act_valid;
  assign out_index = REVERSE ? (LAST_IDX - cnt_q) : cnt_q;
  assign out_data  = act_valid ? act_q[out_index] : '0;
  assign out_last  = act_valid && (cnt_q == LAST_IDX);

endmodule
